// File: rtl/traffic_pkg.sv
// Shared phase encoding and light decode constants for the traffic light
// controller and its output-side monitor.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } phase_e;

    localparam int GREEN_IDX  = 0;
    localparam int YELLOW_IDX = 1;
    localparam int RED_IDX    = 2;

    localparam logic [2:0] L_G = 3'b001 << GREEN_IDX;
    localparam logic [2:0] L_Y = 3'b001 << YELLOW_IDX;
    localparam logic [2:0] L_R = 3'b001 << RED_IDX;

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        n = IDLE;
        case (p)
            GREEN:   n = YELLOW;
            YELLOW:  n = RED;
            RED:     n = GREEN;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_counter.sv
// Saturating seconds counter for the current phase; flags the cycle in
// which the count first rises above the supplied limit.
module phase_duration_counter #(
    parameter int pDUR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  tick_i,
    input  logic [pDUR_WIDTH:0]   limit_i,
    output logic [pDUR_WIDTH-1:0] cnt_o,
    output logic                  over_o
);

    localparam logic [pDUR_WIDTH-1:0] MAX = '1;

    logic [pDUR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = tick_i ? pDUR_WIDTH'(1) : '0;
        end else if (tick_i && cnt_q != MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Crossing detect, so a cleared timeout flag is not re-raised while held
    assign over_o = ({1'b0, cnt_d} > limit_i) && ({1'b0, cnt_q} <= limit_i);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the traffic light controller outputs: tracks phase,
// measures phase length in seconds and latches sticky fault flags.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int pGREEN_SEC  = 15,
    parameter int pYELLOW_SEC = 3,
    parameter int pRED_SEC    = 18,
    parameter int pTOL        = 1,
    parameter int pDUR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  green_light,
    input  logic                  yellow_light,
    input  logic                  red_light,
    input  logic                  sec_tick,
    input  logic                  clr_fault,
    output logic [1:0]            phase,
    output logic [pDUR_WIDTH-1:0] last_dur,
    output logic                  dur_valid,
    output logic                  err_onehot,
    output logic                  err_order,
    output logic                  err_duration,
    output logic                  err_timeout,
    output logic                  fault
);

    function automatic int exp_sec(input phase_e p);
        int e;
        e = 0;
        case (p)
            GREEN:   e = pGREEN_SEC;
            YELLOW:  e = pYELLOW_SEC;
            RED:     e = pRED_SEC;
            default: e = 0;
        endcase
        return e;
    endfunction

    function automatic logic dur_bad(input phase_e p,
                                     input logic [pDUR_WIDTH-1:0] d);
        int di;
        di = int'(d);
        return (di > exp_sec(p) + pTOL) || (di < exp_sec(p) - pTOL);
    endfunction

    phase_e                phase_q, phase_d, lph;
    logic                  first_q, first_d;
    logic [pDUR_WIDTH-1:0] last_q, last_d, dur;
    logic                  dv_q, dv_d;
    logic                  oh_q, oh_d, ord_q, ord_d;
    logic                  du_q, du_d, to_q, to_d, fault_q;
    logic                  new_oh, new_ord, new_du;
    logic                  cnt_clr, cnt_load, over;
    logic                  none, multi;
    logic [2:0]            lights;
    logic [pDUR_WIDTH:0]   lim;

    always_comb begin
        lights             = '0;
        lights[GREEN_IDX]  = green_light;
        lights[YELLOW_IDX] = yellow_light;
        lights[RED_IDX]    = red_light;
        lph   = IDLE;
        none  = 1'b0;
        multi = 1'b0;
        case (lights)
            3'b000:  none  = 1'b1;
            L_G:     lph   = GREEN;
            L_Y:     lph   = YELLOW;
            L_R:     lph   = RED;
            default: multi = 1'b1;
        endcase
    end

    always_comb begin
        phase_d  = phase_q;
        first_d  = first_q;
        last_d   = last_q;
        dv_d     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        new_oh   = 1'b0;
        new_ord  = 1'b0;
        new_du   = 1'b0;
        if (!en) begin
            phase_d = IDLE;
            cnt_clr = 1'b1;
        end else if (phase_q == IDLE) begin
            cnt_clr = 1'b1;
            if (multi) begin
                new_oh = 1'b1;
            end else if (lph == GREEN) begin
                phase_d = GREEN;
                first_d = 1'b1;
            end else if (!none) begin
                phase_d  = lph;
                new_ord  = 1'b1;
                first_d  = 1'b1;
                cnt_clr  = 1'b0;
                cnt_load = 1'b1;
            end
        end else if (none || multi) begin
            new_oh = 1'b1;
        end else if (lph == next_phase(phase_q)) begin
            phase_d  = lph;
            last_d   = dur;
            dv_d     = 1'b1;
            new_du   = !first_q && dur_bad(phase_q, dur);
            first_d  = 1'b0;
            cnt_load = 1'b1;
        end else if (lph != phase_q) begin
            phase_d  = lph;
            new_ord  = 1'b1;
            first_d  = 1'b1;
            cnt_load = 1'b1;
        end
        lim  = (pDUR_WIDTH+1)'(exp_sec(phase_d) + pTOL);
        oh_d  = (clr_fault ? 1'b0 : oh_q)  | new_oh;
        ord_d = (clr_fault ? 1'b0 : ord_q) | new_ord;
        du_d  = (clr_fault ? 1'b0 : du_q)  | new_du;
        to_d  = (clr_fault ? 1'b0 : to_q)
              | (en && phase_d != IDLE && over);
    end

    phase_duration_counter #(.pDUR_WIDTH(pDUR_WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .load_i  (cnt_load),
        .tick_i  (sec_tick),
        .limit_i (lim),
        .cnt_o   (dur),
        .over_o  (over)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= IDLE;
            first_q <= 1'b0;
            last_q  <= '0;
            dv_q    <= 1'b0;
            oh_q    <= 1'b0;
            ord_q   <= 1'b0;
            du_q    <= 1'b0;
            to_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
            last_q  <= last_d;
            dv_q    <= dv_d;
            oh_q    <= oh_d;
            ord_q   <= ord_d;
            du_q    <= du_d;
            to_q    <= to_d;
            fault_q <= oh_d | ord_d | du_d | to_d;
        end
    end

    assign phase        = phase_q;
    assign last_dur     = last_q;
    assign dur_valid    = dv_q;
    assign err_onehot   = oh_q;
    assign err_order    = ord_q;
    assign err_duration = du_q;
    assign err_timeout  = to_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: stimulus queues expected closed-phase lengths and
// status snapshots; a negedge monitor pops and compares them.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst, en, gl, yl, rl, tick, clr;
    logic [1:0] phase;
    logic [5:0] last_dur;
    logic       dur_valid, e_oh, e_ord, e_du, e_to, fault;

    traffic_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .green_light  (gl),
        .yellow_light (yl),
        .red_light    (rl),
        .sec_tick     (tick),
        .clr_fault    (clr),
        .phase        (phase),
        .last_dur     (last_dur),
        .dur_valid    (dur_valid),
        .err_onehot   (e_oh),
        .err_order    (e_ord),
        .err_duration (e_du),
        .err_timeout  (e_to),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] ph;
        logic [4:0] fl;
        bit         chk_ld;
        logic [5:0] ld;
    } st_t;

    st_t sq[$];
    int  dq[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    localparam logic [2:0] NO = 3'b000;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] R  = 3'b100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] fl(input bit oh, input bit od,
                                      input bit du, input bit to);
        return {oh, od, du, to, oh | od | du | to};
    endfunction

    task automatic step(input logic [2:0] l, input logic t);
        {rl, yl, gl} = l;
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [2:0] l, input int n);
        repeat (n) begin
            step(l, 1'b0);
            step(l, 1'b1);
        end
    endtask

    task automatic exp_st(input logic [1:0] ph, input logic [4:0] f,
                          input bit c, input logic [5:0] ld);
        st_t s;
        s.cyc = cyc; s.ph = ph; s.fl = f; s.chk_ld = c; s.ld = ld;
        sq.push_back(s);
    endtask

    always @(negedge clk) begin
        st_t s;
        int  d;
        if (dur_valid) begin
            total++;
            if (dq.size() == 0) begin
                bad++;
                $display("FAIL dur_valid_spurious cyc=%0d last_dur=%0d", cyc, last_dur);
            end else begin
                d = dq.pop_front();
                if (int'(last_dur) != d) begin
                    bad++;
                    $display("FAIL last_dur cyc=%0d got=%0d exp=%0d", cyc, last_dur, d);
                end
            end
        end
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
            s = sq.pop_front();
            total++;
            bad++;
            $display("FAIL stale_check cyc=%0d", s.cyc);
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            total += 2;
            if (phase != s.ph) begin
                bad++;
                $display("FAIL phase cyc=%0d got=%0d exp=%0d", cyc, phase, s.ph);
            end
            if ({e_oh, e_ord, e_du, e_to, fault} != s.fl) begin
                bad++;
                $display("FAIL flags cyc=%0d got=%b exp=%b", cyc,
                         {e_oh, e_ord, e_du, e_to, fault}, s.fl);
            end
            if (s.chk_ld) begin
                total++;
                if (last_dur != s.ld) begin
                    bad++;
                    $display("FAIL reset_last_dur cyc=%0d got=%0d exp=%0d", cyc, last_dur, s.ld);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        step(NO, 1'b0);
        step(NO, 1'b0);
        exp_st(2'd0, fl(0, 0, 0, 0), 1, 6'd0);
        rst = 1'b0; en = 1'b1;
        step(NO, 1'b0);
        exp_st(2'd0, fl(0, 0, 0, 0), 0, 6'd0);

        // nominal cycle
        step(G, 1'b0); exp_st(2'd1, fl(0, 0, 0, 0), 0, 6'd0);
        hold(G, 15);
        step(Y, 1'b0); dq.push_back(15); exp_st(2'd2, fl(0, 0, 0, 0), 0, 6'd0);
        hold(Y, 3);
        step(R, 1'b0); dq.push_back(3);  exp_st(2'd3, fl(0, 0, 0, 0), 0, 6'd0);
        hold(R, 18);
        step(G, 1'b0); dq.push_back(18); exp_st(2'd1, fl(0, 0, 0, 0), 0, 6'd0);
        hold(G, 15);
        step(Y, 1'b0); dq.push_back(15); exp_st(2'd2, fl(0, 0, 0, 0), 0, 6'd0);

        // short yellow
        hold(Y, 1);
        step(R, 1'b0); dq.push_back(1);  exp_st(2'd3, fl(0, 0, 1, 0), 0, 6'd0);
        hold(R, 18);
        clr = 1'b1;
        step(G, 1'b0); dq.push_back(18); exp_st(2'd1, fl(0, 0, 0, 0), 0, 6'd0);
        clr = 1'b0;

        // order violation, then exempt phase
        hold(G, 5);
        step(R, 1'b0); exp_st(2'd3, fl(0, 1, 0, 0), 0, 6'd0);
        hold(R, 4);
        step(G, 1'b0); dq.push_back(4);  exp_st(2'd1, fl(0, 1, 0, 0), 0, 6'd0);

        // illegal combination in yellow, tick still counted
        hold(G, 15);
        step(Y, 1'b0); dq.push_back(15); exp_st(2'd2, fl(0, 1, 0, 0), 0, 6'd0);
        step(G | Y, 1'b1); exp_st(2'd2, fl(1, 1, 0, 0), 0, 6'd0);
        hold(Y, 2);
        step(R, 1'b0); dq.push_back(3);  exp_st(2'd3, fl(1, 1, 0, 0), 0, 6'd0);

        // timeout, clear racing a new error, disable
        clr = 1'b1;
        step(R, 1'b0); exp_st(2'd3, fl(0, 0, 0, 0), 0, 6'd0);
        clr = 1'b0;
        hold(R, 19);
        exp_st(2'd3, fl(0, 0, 0, 0), 0, 6'd0);
        step(R, 1'b1); exp_st(2'd3, fl(0, 0, 0, 1), 0, 6'd0);
        clr = 1'b1;
        step(R | G, 1'b0); exp_st(2'd3, fl(1, 0, 0, 0), 0, 6'd0);
        clr = 1'b0;
        en = 1'b0;
        step(NO, 1'b0); exp_st(2'd0, fl(1, 0, 0, 0), 0, 6'd0);

        // resync from idle, then reset mid-red with fault set
        en = 1'b1;
        step(R, 1'b0); exp_st(2'd3, fl(1, 1, 0, 0), 0, 6'd0);
        hold(R, 2);
        rst = 1'b1;
        step(R, 1'b0); exp_st(2'd0, fl(0, 0, 0, 0), 1, 6'd0);
        rst = 1'b0;
        step(NO, 1'b0); exp_st(2'd0, fl(0, 0, 0, 0), 1, 6'd0);
        step(NO, 1'b0);
        step(NO, 1'b0);

        if (sq.size() != 0 || dq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover sq=%0d dq=%0d exp=0", sq.size(), dq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
